// File: rtl/fetch_sequencer_if.sv
// Bundle of the program-counter, instruction-memory and datapath signals around the fetch
// sequencer.
//   master : sequencer side (drives PC strobe, memory address, instruction, halted)
//   slave  : environment side (program counter, memory, datapath, flags)
//   pc, pc_enable, pc_inc_or_set, pc_new_address : program counter handshake
//   mem_addr, mem_rdata                          : synchronous-read instruction memory
//   instr, instr_valid, exec_done                : datapath handshake
//   jump_target, flag_z, flag_n, flag_c          : branch/jump decision inputs
//   halted                                       : sequencer stopped
interface fetch_sequencer_if;
  logic [15:0] pc;
  logic        pc_enable;
  logic        pc_inc_or_set;
  logic [15:0] pc_new_address;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic [15:0] jump_target;
  logic        flag_z;
  logic        flag_n;
  logic        flag_c;
  logic        halted;

  modport master (
    input  pc, mem_rdata, exec_done, jump_target, flag_z, flag_n, flag_c,
    output pc_enable, pc_inc_or_set, pc_new_address, mem_addr, instr, instr_valid, halted
  );

  modport slave (
    output pc, mem_rdata, exec_done, jump_target, flag_z, flag_n, flag_c,
    input  pc_enable, pc_inc_or_set, pc_new_address, mem_addr, instr, instr_valid, halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches a word from a synchronous-read memory, decodes
// conditional branches (opcode C) and absolute jumps (opcode D) itself, hands every other
// instruction to the datapath and finally strobes the program counter for one cycle.
//   clock  : rising-edge clock
//   reset  : synchronous, active-low
//   io_bus : fetch_sequencer_if master modport (see interface header for signal list)
module fetch_sequencer (
  input logic               clock,
  input logic               reset,
  fetch_sequencer_if.master io_bus
);

  localparam logic [15:0] HaltAddr = 16'hBFFF;

  typedef enum logic [2:0] {StFetch, StWait, StDecode, StExec, StUpdate, StHalt} state_e;

  state_e      r_state;
  logic        r_pc_enable;
  logic        r_pc_inc_or_set;
  logic        r_instr_valid;
  logic        r_halted;
  logic [15:0] r_pc_new_address;
  logic [15:0] r_mem_addr;
  logic [15:0] r_instr;

  logic [3:0]  w_opcode;
  logic [3:0]  w_cond;
  logic        w_cond_true;
  logic [15:0] w_branch_target;

  // Decode works directly on the memory word arriving this cycle, not on r_instr.
  assign w_opcode        = io_bus.mem_rdata[15:12];
  assign w_cond          = io_bus.mem_rdata[11:8];
  assign w_branch_target = io_bus.pc + {{8{io_bus.mem_rdata[7]}}, io_bus.mem_rdata[7:0]};

  always_comb begin
    w_cond_true = 1'b0;
    case (w_cond)
      4'h0:    w_cond_true = io_bus.flag_z;
      4'h1:    w_cond_true = ~io_bus.flag_z;
      4'h2:    w_cond_true = io_bus.flag_c;
      4'h3:    w_cond_true = ~io_bus.flag_c;
      4'h4:    w_cond_true = io_bus.flag_n;
      4'h5:    w_cond_true = ~io_bus.flag_n;
      4'hE:    w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state          <= StFetch;
      r_pc_enable      <= 1'b0;
      r_pc_inc_or_set  <= 1'b0;
      r_pc_new_address <= 16'h0000;
      r_mem_addr       <= 16'h0000;
      r_instr          <= 16'h0000;
      r_instr_valid    <= 1'b0;
      r_halted         <= 1'b0;
    end else begin
      unique case (r_state)
        StFetch: begin
          r_mem_addr <= io_bus.pc;
          r_state    <= StWait;
        end
        StWait: begin
          r_state <= StDecode;
        end
        StDecode: begin
          r_instr <= io_bus.mem_rdata;
          if (w_opcode == 4'hC) begin
            if (w_cond_true) begin
              r_pc_new_address <= w_branch_target;
              r_pc_inc_or_set  <= 1'b1;
            end else begin
              r_pc_inc_or_set  <= 1'b0;
            end
            r_pc_enable <= 1'b1;
            r_state     <= StUpdate;
          end else if (w_opcode == 4'hD) begin
            r_pc_new_address <= io_bus.jump_target;
            r_pc_inc_or_set  <= 1'b1;
            r_pc_enable      <= 1'b1;
            r_state          <= StUpdate;
          end else begin
            r_instr_valid <= 1'b1;
            r_state       <= StExec;
          end
        end
        StExec: begin
          if (io_bus.exec_done) begin
            r_instr_valid   <= 1'b0;
            r_pc_inc_or_set <= 1'b0;
            r_pc_enable     <= 1'b1;
            r_state         <= StUpdate;
          end
        end
        StUpdate: begin
          r_pc_enable <= 1'b0;
          // pc still holds the pre-update address here; an increment past it saturates.
          if (!r_pc_inc_or_set && (io_bus.pc == HaltAddr)) begin
            r_halted <= 1'b1;
            r_state  <= StHalt;
          end else begin
            r_state  <= StFetch;
          end
        end
        StHalt: begin
          r_state <= StHalt;
        end
        default: begin
          r_state <= StFetch;
        end
      endcase
    end
  end

  assign io_bus.pc_enable      = r_pc_enable;
  assign io_bus.pc_inc_or_set  = r_pc_inc_or_set;
  assign io_bus.pc_new_address = r_pc_new_address;
  assign io_bus.mem_addr       = r_mem_addr;
  assign io_bus.instr          = r_instr;
  assign io_bus.instr_valid    = r_instr_valid;
  assign io_bus.halted         = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed cases plus randomized instruction
// streams compared against a per-instruction behavioural model.
module tb_fetch_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clock  (clock),
    .reset  (reset),
    .io_bus (bus)
  );

  // Synchronous-read instruction memory, 256 words aliased over the address space.
  logic [15:0] mem [256];
  always @(posedge clock) bus.mem_rdata <= mem[bus.mem_addr[7:0]];

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] next_pc  = 16'h0000;
  bit          restart  = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_holds(input logic [3:0] c, input logic z, input logic n,
                                    input logic cy);
    case (c)
      4'h0:    return z == 1'b1;
      4'h1:    return z == 1'b0;
      4'h2:    return cy == 1'b1;
      4'h3:    return cy == 1'b0;
      4'h4:    return n == 1'b1;
      4'h5:    return n == 1'b0;
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".pc_enable"}, 32'(bus.pc_enable), 32'd0);
    check_eq({tag, ".pc_inc_or_set"}, 32'(bus.pc_inc_or_set), 32'd0);
    check_eq({tag, ".pc_new_address"}, 32'(bus.pc_new_address), 32'd0);
    check_eq({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check_eq({tag, ".instr"}, 32'(bus.instr), 32'd0);
    check_eq({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'd0);
    check_eq({tag, ".halted"}, 32'(bus.halted), 32'd0);
  endtask

  // Entered at the falling edge inside a FETCH cycle; leaves at the falling edge of the
  // next FETCH cycle. d = EXEC cycles with exec_done low before the completing one.
  task automatic run_instr(input string tag, input logic [15:0] pc, input logic [15:0] word,
                           input logic z, input logic n, input logic cy,
                           input logic [15:0] jt, input int d, input bit rst_exec);
    logic [3:0]  op;
    bit          ctrl;
    bit          taken;
    bit          halt;
    logic [15:0] target;
    int          off;
    int          len;
    int          n_valid;
    int          n_pen;
    int          n_halted;
    logic        pen_last;
    logic        rec_ios;
    logic [15:0] rec_addr;
    logic [15:0] seen_addr;
    logic [15:0] seen_instr;

    op   = word[15:12];
    ctrl = (op == 4'hC) || (op == 4'hD);
    off  = word[7] ? int'(word[7:0]) - 256 : int'(word[7:0]);
    if (op == 4'hD) begin
      taken  = 1'b1;
      target = jt;
    end else if (op == 4'hC) begin
      taken  = cond_holds(word[11:8], z, n, cy);
      target = 16'((int'(pc) + off + 65536) % 65536);
    end else begin
      taken  = 1'b0;
      target = 16'h0000;
    end
    halt = !taken && (pc == 16'hBFFF);
    len  = ctrl ? 4 : 5 + d;

    n_valid    = 0;
    n_pen      = 0;
    n_halted   = 0;
    pen_last   = 1'b0;
    rec_ios    = 1'b0;
    rec_addr   = 16'h0000;
    seen_addr  = 16'h0000;
    seen_instr = 16'h0000;
    bus.pc     = pc;
    mem[pc[7:0]] = word;

    for (int k = 0; k < len; k++) begin
      if (k > 0) @(negedge clock);
      if (bus.instr_valid === 1'b1) n_valid++;
      if (bus.halted !== 1'b0) n_halted++;
      if (bus.pc_enable === 1'b1) begin
        n_pen++;
        rec_ios  = bus.pc_inc_or_set;
        rec_addr = bus.pc_new_address;
      end
      if (k == 0) check_eq({tag, ".pen_idle"}, 32'(bus.pc_enable), 32'd0);
      if (k == 1) seen_addr = bus.mem_addr;
      if (k == 3) seen_instr = bus.instr;
      if (k == len - 1) pen_last = bus.pc_enable;

      // Flags and jump target are scrambled outside DECODE to prove they are ignored.
      if (k == 2) begin
        bus.flag_z = z;  bus.flag_n = n;  bus.flag_c = cy;  bus.jump_target = jt;
      end else begin
        bus.flag_z = 1'($urandom);  bus.flag_n = 1'($urandom);  bus.flag_c = 1'($urandom);
        bus.jump_target = 16'($urandom);
      end
      bus.exec_done = 1'($urandom);
      if (!ctrl && k >= 3 && k < 3 + d) bus.exec_done = 1'b0;
      if (!ctrl && k == 3 + d) bus.exec_done = 1'b1;

      if (rst_exec && !ctrl && k == 3 + d) begin
        reset = 1'b0;
        @(negedge clock);
        check_eq({tag, ".abort_no_pen"}, 32'(n_pen), 32'd0);
        check_reset_vals({tag, ".abort"});
        reset   = 1'b1;
        next_pc = pc;
        return;
      end
    end

    check_eq({tag, ".mem_addr"}, 32'(seen_addr), 32'(pc));
    check_eq({tag, ".instr"}, 32'(seen_instr), 32'(word));
    check_eq({tag, ".valid_cycles"}, 32'(n_valid), ctrl ? 32'd0 : 32'(d + 1));
    check_eq({tag, ".pen_count"}, 32'(n_pen), 32'd1);
    check_eq({tag, ".pen_timing"}, 32'(pen_last), 32'd1);
    check_eq({tag, ".inc_or_set"}, 32'(rec_ios), 32'(taken));
    if (taken) check_eq({tag, ".new_address"}, 32'(rec_addr), 32'(target));
    check_eq({tag, ".not_halted"}, 32'(n_halted), 32'd0);

    @(negedge clock);
    if (halt) begin
      for (int h = 0; h < 4; h++) begin
        check_eq({tag, ".halted"}, 32'(bus.halted), 32'd1);
        check_eq({tag, ".halt_pen"}, 32'(bus.pc_enable), 32'd0);
        check_eq({tag, ".halt_valid"}, 32'(bus.instr_valid), 32'd0);
        check_eq({tag, ".halt_mem_addr"}, 32'(bus.mem_addr), 32'(pc));
        bus.exec_done = 1'($urandom);
        @(negedge clock);
      end
      reset = 1'b0;
      @(negedge clock);
      check_reset_vals({tag, ".unhalt"});
      reset   = 1'b1;
      restart = 1'b1;
    end else begin
      next_pc = taken ? target : pc + 16'd1;
    end
  endtask

  function automatic logic [15:0] rand_word();
    logic [3:0] op;
    case ($urandom_range(0, 3))
      0:       return {4'hC, 4'($urandom_range(0, 15)), 8'($urandom)};
      1:       return {4'hD, 12'($urandom)};
      default: begin
        op = 4'($urandom_range(0, 13));
        if (op >= 4'hC) op = op + 4'd2;
        return {op, 12'($urandom)};
      end
    endcase
  endfunction

  initial begin
    logic [15:0] pc_use;
    logic [15:0] w;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    bus.pc          = 16'h0000;
    bus.exec_done   = 1'b0;
    bus.jump_target = 16'h0000;
    bus.flag_z      = 1'b0;
    bus.flag_n      = 1'b0;
    bus.flag_c      = 1'b0;

    reset = 1'b0;
    bus.exec_done = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset = 1'b1;

    run_instr("plain",      16'h0010, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 1'b0);
    run_instr("br_taken",   16'h0020, 16'hC0FE, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
    run_instr("br_nottkn",  16'h0020, 16'hC0FE, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
    run_instr("br_never",   16'h0020, 16'hCFFE, 1'b1, 1'b1, 1'b1, 16'h0000, 0, 1'b0);
    run_instr("br_wrap",    16'hFFF0, 16'hCE20, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
    run_instr("jump",       16'h0040, 16'hD000, 1'b0, 1'b0, 1'b0, 16'h4000, 0, 1'b0);
    run_instr("br_at_top",  16'hBFFF, 16'hCE05, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
    run_instr("jmp_at_top", 16'hBFFF, 16'hD123, 1'b0, 1'b0, 1'b0, 16'h0100, 0, 1'b0);
    run_instr("halt",       16'hBFFF, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
    run_instr("after_halt", 16'h0050, 16'h5678, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
    run_instr("rst_exec",   16'h0030, 16'h2345, 1'b0, 1'b0, 1'b0, 16'h0000, 2, 1'b1);
    run_instr("after_rst",  16'h0030, 16'h2345, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
    restart = 1'b1;

    for (int i = 0; i < 300; i++) begin
      if (restart || $urandom_range(0, 15) == 0) begin
        pc_use = ($urandom_range(0, 5) == 0) ? 16'hBFFF : 16'($urandom);
      end else begin
        pc_use = next_pc;
      end
      restart = 1'b0;
      w = rand_word();
      run_instr("rand", pc_use, w, 1'($urandom), 1'($urandom), 1'($urandom),
                16'($urandom), int'($urandom_range(0, 3)), $urandom_range(0, 19) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL use reset reset, synchronous, active-low; clock clock.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-low; low at a rising edge forces the reset state.
REQ-004 pc  in  16  current instruction address from the program counter; stable except after a pc_enable cycle.
REQ-005 pc_enable  out  1  program counter update strobe, one cycle wide.
REQ-006 pc_inc_or_set  out  1  0 = increment, 1 = load pc_new_address; meaningful only while pc_enable=1.
REQ-007 pc_new_address  out  16  branch/jump target.
REQ-008 mem_addr  out  16  instruction memory read address, registered.
REQ-009 mem_rdata  in  16  instruction word, valid in the cycle after mem_addr changes (synchronous-read memory).
REQ-010 instr  out  16  latched instruction word for the datapath.
REQ-011 instr_valid  out  1  high while the datapath executes instr.
REQ-012 exec_done  in  1  datapath completion pulse; sampled only in EXEC.
REQ-013 jump_target  in  16  register value for absolute jumps; sampled in DECODE.
REQ-014 flag_z, flag_n, flag_c  in  1 each  condition flags; sampled in DECODE.
REQ-015 halted  out  1  high in HALT.

Function
REQ-016 SHALL implement states FETCH, WAIT, DECODE, EXEC, UPDATE, HALT; one state per cycle except EXEC and HALT.
REQ-017 FETCH: mem_addr <= pc; go to WAIT.
REQ-018 WAIT: no output change; go to DECODE.
REQ-019 DECODE: instr <= mem_rdata; the decision below uses mem_rdata in this same cycle.
REQ-020 Opcode 4'hC (bits 15:12) is a conditional branch: cond = bits 11:8; target = pc + sign-extended bits 7:0, modulo 2^16.
REQ-021 Branch conditions: 0 Z=1, 1 Z=0, 2 C=1, 3 C=0, 4 N=1, 5 N=0, E always; all other codes never.
REQ-022 Opcode 4'hD is an absolute jump: target = jump_target, always taken.
REQ-023 Taken branch or jump: pc_new_address <= target, pc_inc_or_set <= 1, pc_enable <= 1; go to UPDATE; instr_valid stays 0.
REQ-024 Branch not taken: pc_inc_or_set <= 0, pc_enable <= 1; go to UPDATE.
REQ-025 Any other opcode: instr_valid <= 1; go to EXEC.
REQ-026 EXEC: hold until exec_done=1 (including the first EXEC cycle); then instr_valid <= 0, pc_inc_or_set <= 0, pc_enable <= 1; go to UPDATE.
REQ-027 UPDATE: pc_enable is high for exactly this cycle, and the program counter samples it at the closing edge; pc_enable <= 0.
REQ-028 UPDATE exit: if pc_inc_or_set=0 and pc=16'hBFFF (increment saturates), go to HALT; otherwise go to FETCH.
REQ-029 HALT: halted=1, pc_enable=0, instr_valid=0, memory not re-read; left only by reset.
REQ-030 A taken branch or jump from 16'hBFFF SHALL NOT halt.
REQ-031 Minimum latency: 4 cycles FETCH-to-FETCH for a control instruction; 5 cycles for others with immediate exec_done.
REQ-032 exec_done outside EXEC SHALL be ignored; flags and jump_target are ignored outside DECODE.

Reset
REQ-033 While reset=0 at an edge: state=FETCH; pc_enable=0, pc_inc_or_set=0, pc_new_address=0, mem_addr=0, instr=0, instr_valid=0, halted=0.
REQ-034 Reset in any state, including mid-EXEC and HALT, SHALL abort the operation with no pc_enable pulse, and SHALL take priority over exec_done.
REQ-035 First FETCH SHALL occur in the first cycle after reset returns high.

Verification
REQ-036 pc=16'h0010, mem_rdata=16'h1234, exec_done pulsed in the 2nd EXEC cycle -> mem_addr=16'h0010, instr=16'h1234, instr_valid high for 2 cycles, then one pc_enable cycle with pc_inc_or_set=0.
REQ-037 pc=16'h0020, mem_rdata=16'hC0FE, flag_z=1 -> pc_new_address=16'h001E, pc_inc_or_set=1, pc_enable one cycle, instr_valid never high.
REQ-038 Same as REQ-037 with flag_z=0 -> pc_enable with pc_inc_or_set=0; same word with cond 4'hF -> never taken.
REQ-039 pc=16'hFFF0, mem_rdata=16'hCE20 -> pc_new_address=16'h0010 (wrap); mem_rdata=16'hD000, jump_target=16'h4000 -> pc_new_address=16'h4000.
REQ-040 pc=16'hBFFF, non-control instruction, exec_done=1 -> UPDATE, then halted=1 and no further mem_addr change; reset=0 then 1 -> halted=0 and FETCH resumes.
REQ-041 reset=0 asserted during EXEC together with exec_done=1 -> no pc_enable pulse; all outputs at REQ-033 values on the next cycle.
